// File: rtl/alu_arbiter_if.sv
// Signal bundle linking two requesters, the alu_arbiter and a shared combinational ALU.
interface alu_arbiter_if #(
  parameter int unsigned WIDTH = 32
);
  logic [1:0]       req_valid;
  logic [2:0]       req_func0;
  logic [2:0]       req_func1;
  logic [WIDTH-1:0] req_lhs0;
  logic [WIDTH-1:0] req_rhs0;
  logic [WIDTH-1:0] req_lhs1;
  logic [WIDTH-1:0] req_rhs1;
  logic [1:0]       req_ready;
  logic [1:0]       resp_valid;
  logic [1:0]       resp_ready;
  logic [WIDTH-1:0] resp_res;
  logic             resp_zero;
  logic             resp_neg;
  logic             resp_err;
  logic [2:0]       alu_func;
  logic [WIDTH-1:0] alu_lhs;
  logic [WIDTH-1:0] alu_rhs;
  logic [WIDTH-1:0] alu_res;
  logic             alu_zero;
  logic             alu_neg;
  logic             busy;

  modport slave (
    input  req_valid, req_func0, req_func1, req_lhs0, req_rhs0, req_lhs1, req_rhs1,
    input  resp_ready, alu_res, alu_zero, alu_neg,
    output req_ready, resp_valid, resp_res, resp_zero, resp_neg, resp_err,
    output alu_func, alu_lhs, alu_rhs, busy
  );

  modport master (
    output req_valid, req_func0, req_func1, req_lhs0, req_rhs0, req_lhs1, req_rhs1,
    output resp_ready, alu_res, alu_zero, alu_neg,
    input  req_ready, resp_valid, resp_res, resp_zero, resp_neg, resp_err,
    input  alu_func, alu_lhs, alu_rhs, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// one operation in flight at a time (IDLE -> EXEC -> RESP).
module alu_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input logic          clk,
  input logic          rst_n,
  alu_arbiter_if.slave bus
);
  localparam logic [2:0] FUNC_ILLEGAL = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_prio;
  logic             r_grant;
  logic [2:0]       r_func;
  logic [WIDTH-1:0] r_lhs;
  logic [WIDTH-1:0] r_rhs;
  logic [WIDTH-1:0] r_res;
  logic             r_zero;
  logic             r_neg;
  logic             r_err;
  logic             w_grant;
  logic             w_accept;
  logic             w_illegal;
  logic             w_consume;

  // Pointer only matters on a tie; a lone requester always wins.
  assign w_grant   = (bus.req_valid == 2'b11) ? r_prio : bus.req_valid[1];
  assign w_accept  = (r_state == S_IDLE) && (|bus.req_valid);
  assign w_illegal = (r_func == FUNC_ILLEGAL);
  assign w_consume = (r_state == S_RESP) && bus.resp_ready[r_grant];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    bus.req_ready  = 2'b00;
    bus.resp_valid = 2'b00;
    bus.alu_func   = 3'b000;
    bus.alu_lhs    = '0;
    bus.alu_rhs    = '0;
    case (r_state)
      S_IDLE: begin
        // Gated with rst_n so nothing is granted while reset is held.
        if (rst_n && (|bus.req_valid)) begin
          bus.req_ready = w_grant ? 2'b10 : 2'b01;
          w_state_nxt   = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!w_illegal) begin
          bus.alu_func = r_func;
          bus.alu_lhs  = r_lhs;
          bus.alu_rhs  = r_rhs;
        end
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        bus.resp_valid = r_grant ? 2'b10 : 2'b01;
        if (bus.resp_ready[r_grant]) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request latch, response capture and pointer update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio  <= 1'b0;
      r_grant <= 1'b0;
      r_func  <= 3'b000;
      r_lhs   <= '0;
      r_rhs   <= '0;
      r_res   <= '0;
      r_zero  <= 1'b0;
      r_neg   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_grant <= w_grant;
        r_func  <= w_grant ? bus.req_func1 : bus.req_func0;
        r_lhs   <= w_grant ? bus.req_lhs1  : bus.req_lhs0;
        r_rhs   <= w_grant ? bus.req_rhs1  : bus.req_rhs0;
      end
      if (r_state == S_EXEC) begin
        if (w_illegal) begin
          r_res  <= '0;
          r_zero <= 1'b1;
          r_neg  <= 1'b0;
          r_err  <= 1'b1;
        end else begin
          r_res  <= bus.alu_res;
          r_zero <= bus.alu_zero;
          r_neg  <= bus.alu_neg;
          r_err  <= 1'b0;
        end
      end
      if (w_consume) r_prio <= ~r_prio;
    end
  end

  assign bus.resp_res  = r_res;
  assign bus.resp_zero = r_zero;
  assign bus.resp_neg  = r_neg;
  assign bus.resp_err  = r_err;
  assign bus.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic checked every
// cycle against a transaction-level model of the arbiter.
module tb_alu_arbiter;
  localparam int unsigned WIDTH = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  alu_arbiter_if #(.WIDTH(WIDTH)) bus ();
  alu_arbiter #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] alu_op(input logic [2:0] f,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    case (f)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a ^ b;
      3'b101:  return WIDTH'($signed(a) < $signed(b));
      3'b111:  return WIDTH'(a < b);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Shared ALU seen by the arbiter; garbage on the illegal code exposes misuse.
  assign bus.alu_res  = alu_op(bus.alu_func, bus.alu_lhs, bus.alu_rhs);
  assign bus.alu_zero = (bus.alu_res == '0);
  assign bus.alu_neg  = bus.alu_res[WIDTH-1];

  // Expected response {err, neg, zero, res} for a request.
  function automatic logic [WIDTH+2:0] ref_resp(input logic [2:0] f,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    if (f == 3'b110) return {1'b1, 1'b0, 1'b1, WIDTH'(0)};
    r = alu_op(f, a, b);
    return {1'b0, r[WIDTH-1], (r == '0), r};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: free, or holding one op that is executing or awaiting consumption.
  logic             m_busy = 1'b0;
  logic             m_resp = 1'b0;
  logic             m_grant = 1'b0;
  logic             m_ptr = 1'b0;
  logic [2:0]       m_func = 3'b000;
  logic [WIDTH-1:0] m_lhs = '0;
  logic [WIDTH-1:0] m_rhs = '0;

  always @(negedge clk) begin : model
    logic [1:0]       exp_ready;
    logic [1:0]       exp_rv;
    logic             g;
    logic [WIDTH+2:0] er;
    logic             drive_alu;
    if (!rst_n) begin
      chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
      chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
      chk("rst_resp_res", 64'(bus.resp_res), 64'd0);
      chk("rst_flags", 64'({bus.resp_zero, bus.resp_neg, bus.resp_err}), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_alu", 64'({bus.alu_func, bus.alu_lhs, bus.alu_rhs}), 64'd0);
      m_busy = 1'b0;
      m_resp = 1'b0;
      m_ptr  = 1'b0;
    end else begin
      exp_ready = 2'b00;
      exp_rv    = 2'b00;
      g         = (bus.req_valid == 2'b11) ? m_ptr : bus.req_valid[1];
      if (!m_busy && bus.req_valid != 2'b00) exp_ready = g ? 2'b10 : 2'b01;
      if (m_resp) exp_rv = m_grant ? 2'b10 : 2'b01;
      drive_alu = m_busy && !m_resp && (m_func != 3'b110);
      chk("m_req_ready", 64'(bus.req_ready), 64'(exp_ready));
      chk("m_busy", 64'(bus.busy), 64'(m_busy));
      chk("m_resp_valid", 64'(bus.resp_valid), 64'(exp_rv));
      chk("m_alu_func", 64'(bus.alu_func), drive_alu ? 64'(m_func) : 64'd0);
      chk("m_alu_lhs", 64'(bus.alu_lhs), drive_alu ? 64'(m_lhs) : 64'd0);
      chk("m_alu_rhs", 64'(bus.alu_rhs), drive_alu ? 64'(m_rhs) : 64'd0);
      if (m_resp) begin
        er = ref_resp(m_func, m_lhs, m_rhs);
        chk("m_resp_res", 64'(bus.resp_res), 64'(er[WIDTH-1:0]));
        chk("m_resp_flags", 64'({bus.resp_err, bus.resp_neg, bus.resp_zero}),
            64'(er[WIDTH+2:WIDTH]));
      end
      // Advance to what must hold after the coming rising edge.
      if (!m_busy) begin
        if (bus.req_valid != 2'b00) begin
          m_busy  = 1'b1;
          m_resp  = 1'b0;
          m_grant = g;
          m_func  = g ? bus.req_func1 : bus.req_func0;
          m_lhs   = g ? bus.req_lhs1  : bus.req_lhs0;
          m_rhs   = g ? bus.req_rhs1  : bus.req_rhs0;
        end
      end else if (!m_resp) begin
        m_resp = 1'b1;
      end else if (bus.resp_ready[m_grant]) begin
        m_busy = 1'b0;
        m_resp = 1'b0;
        m_ptr  = ~m_ptr;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] f,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (i == 0) begin
      bus.req_func0 = f; bus.req_lhs0 = a; bus.req_rhs0 = b;
    end else begin
      bus.req_func1 = f; bus.req_lhs1 = a; bus.req_rhs1 = b;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [WIDTH-1:0] rnd_operand();
    case ($urandom_range(0, 3))
      0:       return WIDTH'($urandom_range(0, 3));
      1:       return {WIDTH{1'b1}};
      default: return WIDTH'($urandom);
    endcase
  endfunction

  initial begin
    bus.req_valid  = 2'b11;
    bus.resp_ready = 2'b00;
    set_req(0, 3'b000, '0, '0);
    set_req(1, 3'b000, '0, '0);

    // Reset state with both requesters asserting.
    @(negedge clk);
    chk("reset_req_ready", 64'(bus.req_ready), 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    tick();
    rst_n = 1'b1;

    // Single ADD 5+7.
    bus.req_valid = 2'b01; bus.resp_ready = 2'b11;
    set_req(0, 3'b000, 32'd5, 32'd7);
    @(negedge clk); chk("add_ready", 64'(bus.req_ready), 64'h1);
    tick(); bus.req_valid = 2'b00;
    @(negedge clk); chk("add_exec_func", 64'(bus.alu_func), 64'h0);
    chk("add_exec_lhs", 64'(bus.alu_lhs), 64'd5);
    tick();
    @(negedge clk); chk("add_rv", 64'(bus.resp_valid), 64'h1);
    chk("add_res", 64'(bus.resp_res), 64'd12);
    chk("add_flags", 64'({bus.resp_zero, bus.resp_neg}), 64'h0);
    tick();

    // SUB 1-2: negative result; lone req0 wins despite pointer at 1.
    bus.req_valid = 2'b01;
    set_req(0, 3'b001, 32'd1, 32'd2);
    @(negedge clk); chk("sub_ready_lone", 64'(bus.req_ready), 64'h1);
    tick(); bus.req_valid = 2'b00;
    tick();
    @(negedge clk); chk("sub_res", 64'(bus.resp_res), 64'hFFFF_FFFF);
    chk("sub_neg", 64'(bus.resp_neg), 64'h1);
    chk("sub_zero", 64'(bus.resp_zero), 64'h0);
    tick();

    // Contention from reset, then back-to-back alternation.
    do_reset();
    bus.req_valid = 2'b11;
    set_req(0, 3'b001, 32'd3, 32'd3);
    set_req(1, 3'b101, 32'hFFFF_FFFF, 32'd1);
    @(negedge clk); chk("cont_first_grant", 64'(bus.req_ready), 64'h1);
    tick();
    @(negedge clk); chk("cont_wait_exec", 64'(bus.req_ready), 64'h0);
    tick();
    @(negedge clk); chk("cont_res0", 64'(bus.resp_res), 64'd0);
    chk("cont_zero0", 64'(bus.resp_zero), 64'h1);
    chk("cont_wait_resp", 64'(bus.req_ready), 64'h0);
    tick();
    @(negedge clk); chk("cont_second_grant", 64'(bus.req_ready), 64'h2);
    tick(); tick();
    @(negedge clk); chk("cont_res1", 64'(bus.resp_res), 64'd1);
    chk("cont_rv1", 64'(bus.resp_valid), 64'h2);
    tick();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); chk("alt_grant", 64'(bus.req_ready), (k % 2 == 0) ? 64'h1 : 64'h2);
      tick(); tick(); tick();
    end

    // Backpressure on req1 XOR while req0 waits; wrong-index ready is ignored.
    bus.req_valid = 2'b10; bus.resp_ready = 2'b00;
    set_req(1, 3'b100, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
    set_req(0, 3'b000, 32'd9, 32'd9);
    @(negedge clk); chk("bp_grant", 64'(bus.req_ready), 64'h2);
    tick(); bus.req_valid = 2'b01;
    tick(); bus.resp_ready = 2'b01;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); chk("bp_rv", 64'(bus.resp_valid), 64'h2);
      chk("bp_res", 64'(bus.resp_res), 64'hFFFF_FFFF);
      chk("bp_req0_held", 64'(bus.req_ready), 64'h0);
      tick();
    end
    bus.resp_ready = 2'b10;
    tick();
    @(negedge clk); chk("bp_req0_now", 64'(bus.req_ready), 64'h1);
    tick(); bus.req_valid = 2'b00; bus.resp_ready = 2'b11;
    repeat (3) tick();

    // Illegal function code from req1.
    bus.req_valid = 2'b10;
    set_req(1, 3'b110, 32'h1234_5678, 32'h0000_0042);
    @(negedge clk); chk("ill_grant", 64'(bus.req_ready), 64'h2);
    tick(); bus.req_valid = 2'b00;
    @(negedge clk); chk("ill_alu_func", 64'(bus.alu_func), 64'h0);
    chk("ill_alu_lhs", 64'(bus.alu_lhs), 64'h0);
    tick();
    @(negedge clk); chk("ill_err", 64'(bus.resp_err), 64'h1);
    chk("ill_res", 64'(bus.resp_res), 64'h0);
    chk("ill_zero", 64'(bus.resp_zero), 64'h1);
    tick(); tick();

    // Reset during EXEC of SLTU, then a clean op and first tie goes to req0.
    bus.req_valid = 2'b01;
    set_req(0, 3'b111, 32'hFFFF_FFFF, 32'd1);
    @(negedge clk); chk("rst_op_grant", 64'(bus.req_ready), 64'h1);
    tick(); bus.req_valid = 2'b00;
    chk("rst_op_busy", 64'(bus.busy), 64'h1);
    rst_n = 1'b0;
    #1;
    chk("async_busy", 64'(bus.busy), 64'h0);
    chk("async_alu", 64'({bus.alu_func, bus.alu_lhs}), 64'h0);
    chk("async_err", 64'(bus.resp_err), 64'h0);
    chk("async_zero", 64'(bus.resp_zero), 64'h0);
    tick(); rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); chk("aborted_no_resp", 64'(bus.resp_valid), 64'h0);
      tick();
    end
    bus.req_valid = 2'b11;
    set_req(1, 3'b000, 32'd1, 32'd1);
    @(negedge clk); chk("post_rst_grant", 64'(bus.req_ready), 64'h1);
    tick(); bus.req_valid = 2'b00;
    tick();
    @(negedge clk); chk("post_rst_res", 64'(bus.resp_res), 64'h0);
    chk("post_rst_rv", 64'(bus.resp_valid), 64'h1);
    tick(); tick();

    // Random traffic with occasional asynchronous resets.
    for (int c = 0; c < 3000; c++) begin
      bus.req_valid  = 2'($urandom);
      bus.resp_ready = 2'($urandom);
      set_req(0, 3'($urandom), rnd_operand(), rnd_operand());
      set_req(1, 3'($urandom), rnd_operand(), rnd_operand());
      rst_n = ($urandom_range(0, 399) != 0);
      tick();
    end
    rst_n = 1'b1;
    bus.req_valid = 2'b00;
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
